neuron_seq_ctrl: RTL and testbench
==================================

Name: neuron_seq_ctrl

Overview:
Sequencer for a single `neuron` MAC datapath, which holds an 18-bit FloPoCo-format accumulator.
- On a start request it clears the neuron accumulator.
- It then streams LEN weight/data pairs from two synchronous-read memories, asserting the neuron enable exactly on the cycles when memory data is valid.
- It captures the final accumulator and returns it with an optional ReLU applied.
- It sits between the layer scheduler (start/result handshake) and one neuron instance plus its weight/data RAMs.

Parameters:
- BITWIDTH, 16, IEEE-half payload width.
- BW, BITWIDTH+1, MSB index of FloPoCo word (word is BW+1 = 18 bits).
- ADDR_W, 10, weight/data memory address width.
- LEN_W, 11, width of vector-length input (max LEN = 2^ADDR_W).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only in IDLE.
- len  in  LEN_W  number of MAC pairs; sampled with start.
- w_base  in  ADDR_W  weight start address; sampled with start.
- d_base  in  ADDR_W  data start address; sampled with start.
- relu  in  1  apply ReLU to result; sampled with start.
- abort  in  1  cancel current job.
- busy  out  1  high from the cycle after start acceptance until capture completes.
- mem_rd_en  out  1  read strobe for both RAMs (1-cycle read latency).
- w_addr  out  ADDR_W  weight RAM address.
- d_addr  out  ADDR_W  data RAM address.
- neu_clear  out  1  to neuron clear.
- neu_en  out  1  to neuron en.
- neu_accum  in  BW+1  neuron accumulator.
- result  out  BW+1  final (optionally ReLU'd) value.
- result_valid  out  1  one-cycle pulse.

Behaviour:
- Reset values:
  - state IDLE.
  - busy, mem_rd_en, neu_clear, neu_en, result_valid all 0.
  - result 0; w_addr/d_addr 0; index counter 0.
- States: IDLE, CLEAR, RUN, CAPT.
- IDLE:
  - On start=1, latch len/w_base/d_base/relu and go to CLEAR.
  - start is ignored in every other state; no queueing.
- CLEAR (1 cycle):
  - neu_clear=1, mem_rd_en=1, addresses = bases + 0.
  - Next state is RUN if len>0, else CAPT.
- RUN (len cycles, index i = 0..len-1):
  - neu_en=1 every cycle (RAM data for index i is valid).
  - If i+1 < len: mem_rd_en=1, addresses = bases + i + 1.
  - Otherwise mem_rd_en=0.
  - After i = len-1, go to CAPT.
- CAPT (1 cycle):
  - neu_accum is final here.
  - Register result (ReLU'd if relu latched) and set result_valid=1 for the next cycle.
  - Go to IDLE.
- Latency: start sampled at cycle 0 → result_valid high at cycle len+3. busy is high in cycles 1..len+2. A new start may be accepted in the same cycle result_valid is high.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top of memory is legal and silent.
- len=0: still clears; result = 0 (18'h00000), latency 3.
- len > 2^ADDR_W is out of range; it is clamped to 2^ADDR_W.
- ReLU, using FloPoCo fields (exc = [BW:BW-1], sign = [BW-2]):
  - If relu and sign=1 and exc != 2'b11, result = 0.
  - NaN (exc 11) passes unchanged.
  - Positive values and zero pass unchanged.
- result holds its value until the next CAPT.
- abort=1 in CLEAR/RUN/CAPT: next cycle is IDLE with all strobes 0; no result_valid; result unchanged. abort in IDLE has no effect. abort and start together in IDLE: abort wins (start dropped).
- rst mid-operation: immediate return to reset values. The neuron's own reset is driven by the same rst.

Decomposition:
- Shared package `neuron_pkg`:
  - state enum type.
  - FloPoCo exception-code constants (EXC_ZERO=2'b00, EXC_NORM=2'b01, EXC_INF=2'b10, EXC_NAN=2'b11).
  - FP_ZERO constant (all 18 bits zero).
  - field-index localparams.
- One combinational sub-module `fp_relu` (in BW+1, en, out), reused later by layer-level blocks.
- The neuron itself is instantiated by the parent, not inside this block.

Test Plan:
- len=3, w=18'h13C00 (1.0) ×3, d=18'h14000 (2.0) ×3, relu=0 → result 18'h14600 (6.0); result_valid exactly at cycle 6; neu_en high cycles 2–4; neu_clear high cycle 1 only.
- Same as the first scenario but data is 18'h1C000 (-2.0), relu=1 → result 18'h00000. With relu=0 → 18'h1C600.
- len=0 → result 18'h00000, result_valid at cycle 3, mem_rd_en never high after CLEAR, neu_en never high.
- w_base=10'h3FE, len=4 → w_addr sequence 3FE, 3FF, 000, 001; result correct.
- abort asserted in the 2nd RUN cycle of len=5 → IDLE next cycle, no result_valid, result keeps the previous value. A following start with len=1 completes normally at latency 4.
- Back-to-back: start held high continuously → second job accepted in the cycle the first job's result_valid is high. Also: rst pulsed mid-RUN → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared sizes, FloPoCo field layout and sequencer state type
package neuron_pkg;
    localparam int NEU_BITWIDTH = 16;
    localparam int NEU_BW = NEU_BITWIDTH + 1;
    localparam int NEU_ADDR_W = 10;
    localparam int NEU_LEN_W = 11;
    localparam int FP_EXC_HI = NEU_BW;
    localparam int FP_EXC_LO = NEU_BW - 1;
    localparam int FP_SIGN = NEU_BW - 2;
    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF = 2'b10;
    localparam logic [1:0] EXC_NAN = 2'b11;
    localparam logic [NEU_BW:0] FP_ZERO = '0;
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_CAPT} state_e;
endpackage

// File: rtl/fp_relu.sv
// fp_relu: zeroes negative FloPoCo values when enabled; NaN passes through
module fp_relu
    import neuron_pkg::*;
(
    input  logic [NEU_BW:0] in_i,
    input  logic            en_i,
    output logic [NEU_BW:0] out_o
);
    assign out_o = (en_i && in_i[FP_SIGN] && in_i[FP_EXC_HI:FP_EXC_LO] != EXC_NAN) ? FP_ZERO : in_i;
endmodule

// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: clears, streams LEN weight/data pairs into one neuron, returns the ReLU'd accumulator
module neuron_seq_ctrl
    import neuron_pkg::*;
#(
    parameter int BITWIDTH = NEU_BITWIDTH,
    parameter int BW = BITWIDTH + 1,
    parameter int ADDR_W = NEU_ADDR_W,
    parameter int LEN_W = NEU_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] d_base,
    input  logic              relu,
    input  logic              abort,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] d_addr,
    output logic              neu_clear,
    output logic              neu_en,
    input  logic [BW:0]       neu_accum,
    output logic [BW:0]       result,
    output logic              result_valid
);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(1 << ADDR_W);
    state_e state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, nxt;
    logic [ADDR_W-1:0] w_base_q, w_base_d, d_base_q, d_base_d, off;
    logic relu_q, relu_d, valid_q, valid_d;
    logic [BW:0] result_q, result_d, relu_val;
    fp_relu u_relu (
        .in_i  (neu_accum),
        .en_i  (relu_q),
        .out_o (relu_val)
    );
    // idx_q is the index whose RAM data is valid this RUN cycle; nxt is the one being fetched
    assign nxt = idx_q + LEN_W'(1);
    assign busy = state_q != S_IDLE;
    assign neu_clear = state_q == S_CLEAR;
    assign neu_en = state_q == S_RUN;
    assign mem_rd_en = neu_clear || (neu_en && nxt < len_q);
    assign off = neu_clear ? '0 : nxt[ADDR_W-1:0];
    assign w_addr = mem_rd_en ? w_base_q + off : '0;
    assign d_addr = mem_rd_en ? d_base_q + off : '0;
    assign result = result_q;
    assign result_valid = valid_q;
    always_comb begin
        state_d = state_q;
        len_d = len_q;
        idx_d = idx_q;
        w_base_d = w_base_q;
        d_base_d = d_base_q;
        relu_d = relu_q;
        result_d = result_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: if (start && !abort) begin
                state_d = S_CLEAR;
                len_d = (len > LEN_MAX) ? LEN_MAX : len;
                idx_d = '0;
                w_base_d = w_base;
                d_base_d = d_base;
                relu_d = relu;
            end
            S_CLEAR: state_d = (len_q == '0) ? S_CAPT : S_RUN;
            S_RUN: begin
                idx_d = nxt;
                state_d = (nxt >= len_q) ? S_CAPT : S_RUN;
            end
            default: begin
                state_d = S_IDLE;
                result_d = relu_val;
                valid_d = 1'b1;
            end
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            result_d = result_q;
            valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q <= '0;
            idx_q <= '0;
            w_base_q <= '0;
            d_base_q <= '0;
            relu_q <= 1'b0;
            result_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            idx_q <= idx_d;
            w_base_q <= w_base_d;
            d_base_q <= d_base_d;
            relu_q <= relu_d;
            result_q <= result_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// tb_neuron_seq_ctrl: directed job table plus abort/back-to-back/reset sequences against RAM and neuron models
module tb_neuron_seq_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, relu = 1'b0, abort = 1'b0;
    logic [10:0] len = '0;
    logic [9:0] w_base = '0, d_base = '0;
    logic busy, mem_rd_en, neu_clear, neu_en, result_valid;
    logic [9:0] w_addr, d_addr;
    logic [17:0] neu_accum, result;
    logic ovr_en = 1'b0;
    logic [17:0] ovr_val = '0;
    int n_chk = 0, n_fail = 0;
    int w_mem [1024];
    int d_mem [1024];
    int w_q = 0, d_q = 0, acc = 0;
    int en_cnt = 0, clr_cnt = 0, rd_cnt = 0;
    logic [9:0] wq [$];
    logic [9:0] dq [$];
    typedef struct {
        int len;
        logic [9:0] wb;
        logic [9:0] db;
        logic relu;
        logic ovr_en;
        logic [17:0] ovr;
        logic [17:0] exp_res;
        int exp_lat;
    } job_t;
    job_t jobs [12];
    neuron_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .w_base(w_base), .d_base(d_base),
        .relu(relu), .abort(abort), .busy(busy), .mem_rd_en(mem_rd_en), .w_addr(w_addr),
        .d_addr(d_addr), .neu_clear(neu_clear), .neu_en(neu_en), .neu_accum(neu_accum),
        .result(result), .result_valid(result_valid)
    );
    always #5 clk = ~clk;
    function automatic logic [17:0] fp_of(input int v);
        int a, e;
        if (v == 0) return '0;
        a = (v < 0) ? -v : v;
        e = 0;
        for (int k = 0; k < 31; k++) if ((a >> k) != 0) e = k;
        return {2'b01, v < 0, 5'(e + 15), 10'((a << 10) >> e)};
    endfunction
    assign neu_accum = ovr_en ? ovr_val : fp_of(acc);
    always @(posedge clk) begin
        if (mem_rd_en) begin
            w_q <= w_mem[w_addr];
            d_q <= d_mem[d_addr];
            wq.push_back(w_addr);
            dq.push_back(d_addr);
        end
        acc <= (rst || neu_clear) ? 0 : neu_en ? acc + w_q * d_q : acc;
        en_cnt <= en_cnt + int'(neu_en);
        clr_cnt <= clr_cnt + int'(neu_clear);
        rd_cnt <= rd_cnt + int'(mem_rd_en);
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " mem_rd_en"}, mem_rd_en, 0);
        chk({tag, " neu_clear"}, neu_clear, 0);
        chk({tag, " neu_en"}, neu_en, 0);
        chk({tag, " result_valid"}, result_valid, 0);
        chk({tag, " w_addr"}, w_addr, 0);
        chk({tag, " d_addr"}, d_addr, 0);
    endtask
    task automatic run_job(input int id, input job_t j);
        int lat, busy_n, en0, clr0, rd0, q0, n_rd, exp_len, bad;
        string p;
        p = $sformatf("job%0d", id);
        exp_len = (j.len > 1024) ? 1024 : j.len;
        @(negedge clk);
        start = 1'b1;
        len = 11'(j.len);
        w_base = j.wb;
        d_base = j.db;
        relu = j.relu;
        ovr_en = j.ovr_en;
        ovr_val = j.ovr;
        en0 = en_cnt;
        clr0 = clr_cnt;
        rd0 = rd_cnt;
        q0 = wq.size();
        lat = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            busy_n += int'(busy);
        end while (!result_valid && lat < 1100);
        chk({p, " latency"}, lat, j.exp_lat);
        chk({p, " result"}, result, j.exp_res);
        chk({p, " busy_cycles"}, busy_n, j.exp_lat - 1);
        chk({p, " clear_pulses"}, clr_cnt - clr0, 1);
        chk({p, " en_cycles"}, en_cnt - en0, exp_len);
        n_rd = rd_cnt - rd0;
        chk({p, " rd_cycles"}, n_rd, (exp_len == 0) ? 1 : exp_len);
        bad = 0;
        for (int k = 0; k < n_rd && q0 + k < wq.size(); k++)
            if (wq[q0 + k] != 10'(j.wb + k) || dq[q0 + k] != 10'(j.db + k)) bad++;
        chk({p, " addr_seq"}, bad, 0);
    endtask
    initial begin
        int nv, lat;
        job_t one;
        for (int i = 0; i < 1024; i++) begin
            w_mem[i] = 5;
            d_mem[i] = 5;
        end
        for (int i = 0; i < 5; i++) begin
            w_mem[i] = 1;
            d_mem[10'h100 + i] = 2;
        end
        w_mem[10'h3FE] = 1;
        w_mem[10'h3FF] = 1;
        for (int i = 0; i < 3; i++) d_mem[10'h200 + i] = -2;
        for (int i = 0; i < 4; i++) d_mem[10'h300 + i] = 3;
        jobs[0]  = '{3,    10'h000, 10'h100, 1'b0, 1'b0, 18'h0,     18'h14600, 6};
        jobs[1]  = '{3,    10'h000, 10'h200, 1'b1, 1'b0, 18'h0,     18'h00000, 6};
        jobs[2]  = '{3,    10'h000, 10'h200, 1'b0, 1'b0, 18'h0,     18'h1C600, 6};
        jobs[3]  = '{0,    10'h3FF, 10'h010, 1'b1, 1'b0, 18'h0,     18'h00000, 3};
        jobs[4]  = '{4,    10'h3FE, 10'h300, 1'b0, 1'b0, 18'h0,     18'h14A00, 7};
        jobs[5]  = '{1,    10'h000, 10'h100, 1'b0, 1'b0, 18'h0,     18'h14000, 4};
        jobs[6]  = '{0,    10'h000, 10'h000, 1'b1, 1'b1, 18'h3C000, 18'h3C000, 3};
        jobs[7]  = '{0,    10'h000, 10'h000, 1'b1, 1'b1, 18'h2C000, 18'h00000, 3};
        jobs[8]  = '{0,    10'h000, 10'h000, 1'b1, 1'b1, 18'h08000, 18'h00000, 3};
        jobs[9]  = '{0,    10'h000, 10'h000, 1'b0, 1'b1, 18'h08000, 18'h08000, 3};
        jobs[10] = '{2000, 10'h005, 10'h007, 1'b0, 1'b1, 18'h14000, 18'h14000, 1027};
        jobs[11] = '{0,    10'h000, 10'h000, 1'b1, 1'b1, 18'h14600, 18'h14600, 3};
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset result", result, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");
        for (int i = 0; i < 12; i++) run_job(i, jobs[i]);
        @(negedge clk);
        start = 1'b1; len = 11'd5; w_base = 10'h000; d_base = 10'h100; relu = 1'b0; ovr_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort run_en", neu_en, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle_outputs("abort");
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            nv += int'(result_valid);
        end
        chk("abort no_valid", nv, 0);
        chk("abort result_kept", result, 18'h14600);
        one = '{1, 10'h000, 10'h100, 1'b0, 1'b0, 18'h0, 18'h14000, 4};
        run_job(100, one);
        @(negedge clk);
        start = 1'b1; abort = 1'b1; len = 11'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("idle_abort busy", busy, 0);
        chk("idle_abort clear", neu_clear, 0);
        @(negedge clk);
        start = 1'b1; len = 11'd2; w_base = 10'h000; d_base = 10'h100;
        repeat (5) @(negedge clk);
        chk("b2b valid", result_valid, 1);
        chk("b2b busy_gap", busy, 0);
        chk("b2b result", result, 18'h14400);
        @(negedge clk);
        start = 1'b0;
        chk("b2b second_busy", busy, 1);
        chk("b2b second_clear", neu_clear, 1);
        lat = 1;
        while (!result_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b second_latency", lat, 5);
        chk("b2b second_result", result, 18'h14400);
        @(negedge clk);
        start = 1'b1; len = 11'd5; d_base = 10'h200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("mid_rst");
        chk("mid_rst result", result, 0);
        nv = 0;
        repeat (5) begin
            @(negedge clk);
            nv += int'(busy) + int'(result_valid);
        end
        chk("mid_rst stays_idle", nv, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
